// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: walks one instruction at a time through
// icache request, response capture and predictor-steered enqueue, with flush redirect.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        flush,
    input  logic [31:0] flush_pc,

    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_inst,

    output logic        pd_ena,
    output logic [31:0] pd_pc,
    output logic [31:0] pd_inst,
    input  logic        pd_taken_stat,
    input  logic [31:0] pd_off,

    input  logic        iq_full,
    output logic        iq_push,
    output logic [31:0] iq_pc,
    output logic [31:0] iq_inst,
    output logic        iq_pred_taken
);

    localparam logic [31:0] PcAlignMask = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StIssue,
        StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        pd_ena_q, pd_ena_d;
    logic [31:0] next_seq_pc;

    assign next_seq_pc = pd_taken_stat ? (pc_q + pd_off) : (pc_q + 32'd4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_buf_d   = inst_buf_q;
        pd_ena_d     = 1'b1;
        ic_req_valid = 1'b0;
        iq_push      = 1'b0;

        if (rst) begin
            state_d    = StFetch;
            pc_d       = RESET_PC & PcAlignMask;
            inst_buf_d = 32'd0;
            pd_ena_d   = 1'b0;
        end else if (flush) begin
            pc_d = flush_pc & PcAlignMask;
            // A request still in flight must be absorbed before fetching again.
            if ((state_q == StWait || state_q == StDrain) && !ic_resp_valid) begin
                state_d = StDrain;
            end else begin
                state_d = StFetch;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    ic_req_valid = 1'b1;
                    state_d      = StWait;
                end
                StWait: begin
                    if (ic_resp_valid) begin
                        inst_buf_d = ic_resp_inst;
                        state_d    = StIssue;
                    end
                end
                StIssue: begin
                    if (!iq_full) begin
                        iq_push = 1'b1;
                        pc_d    = next_seq_pc & PcAlignMask;
                        state_d = StFetch;
                    end
                end
                StDrain: begin
                    if (ic_resp_valid) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        pc_q       <= pc_d;
        inst_buf_q <= inst_buf_d;
        pd_ena_q   <= pd_ena_d;
    end

    assign ic_req_addr   = pc_q;
    assign pd_ena        = pd_ena_q;
    assign pd_pc         = pc_q;
    assign pd_inst       = inst_buf_q;
    assign iq_pc         = pc_q;
    assign iq_inst       = inst_buf_q;
    assign iq_pred_taken = pd_taken_stat;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus a randomized run against a
// transaction-level model (pending request / in-flight / discard / ready flags).
module tb_ifetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] ALIGN  = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_inst;
    logic        pd_ena;
    logic [31:0] pd_pc;
    logic [31:0] pd_inst;
    logic        pd_taken_stat;
    logic [31:0] pd_off;
    logic        iq_full;
    logic        iq_push;
    logic [31:0] iq_pc;
    logic [31:0] iq_inst;
    logic        iq_pred_taken;

    int checks;
    int failures;

    // Model state: what the fetcher owes next, not how the RTL encodes it.
    logic [31:0] m_pc;
    logic [31:0] m_buf;
    bit          m_need_req;
    bit          m_inflight;
    bit          m_discard;
    bit          m_ready;
    bit          m_ena;

    ifetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .ic_req_valid  (ic_req_valid),
        .ic_req_addr   (ic_req_addr),
        .ic_resp_valid (ic_resp_valid),
        .ic_resp_inst  (ic_resp_inst),
        .pd_ena        (pd_ena),
        .pd_pc         (pd_pc),
        .pd_inst       (pd_inst),
        .pd_taken_stat (pd_taken_stat),
        .pd_off        (pd_off),
        .iq_full       (iq_full),
        .iq_push       (iq_push),
        .iq_pc         (iq_pc),
        .iq_inst       (iq_inst),
        .iq_pred_taken (iq_pred_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_step();
        if (rst) begin
            m_pc       = RST_PC & ALIGN;
            m_buf      = 32'd0;
            m_need_req = 1'b1;
            m_inflight = 1'b0;
            m_discard  = 1'b0;
            m_ready    = 1'b0;
            m_ena      = 1'b0;
        end else begin
            m_ena = 1'b1;
            if (flush) begin
                m_pc = flush_pc & ALIGN;
                if (m_inflight && !ic_resp_valid) begin
                    m_discard = 1'b1;
                end else begin
                    m_inflight = 1'b0;
                    m_discard  = 1'b0;
                    m_ready    = 1'b0;
                    m_need_req = 1'b1;
                end
            end else if (m_need_req) begin
                m_need_req = 1'b0;
                m_inflight = 1'b1;
                m_discard  = 1'b0;
            end else if (m_inflight) begin
                if (ic_resp_valid) begin
                    m_inflight = 1'b0;
                    if (m_discard) begin
                        m_discard  = 1'b0;
                        m_need_req = 1'b1;
                    end else begin
                        m_buf   = ic_resp_inst;
                        m_ready = 1'b1;
                    end
                end
            end else if (m_ready && !iq_full) begin
                m_ready    = 1'b0;
                m_need_req = 1'b1;
                m_pc       = (m_pc + (pd_taken_stat ? pd_off : 32'd4)) & ALIGN;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        rst           = 1'b0;
        flush         = 1'b0;
        flush_pc      = 32'd0;
        ic_resp_valid = 1'b0;
        ic_resp_inst  = 32'd0;
        pd_taken_stat = 1'b0;
        pd_off        = 32'd0;
        iq_full       = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst      = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'h0000_0400;
        #1;
        checks++;
        if (ic_req_valid !== 1'b0 || iq_push !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b push=%b, want 0 0", ic_req_valid, iq_push);
        end
        tick();
        #1;
        checks++;
        if (pd_ena !== 1'b0 || pd_pc !== RST_PC || pd_inst !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: ena=%b pc=%h inst=%h, want 0 %h 0", pd_ena, pd_pc,
                     pd_inst, RST_PC);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (ic_req_valid !== 1'b1 || ic_req_addr !== RST_PC || pd_ena !== 1'b0) begin
            failures++;
            $display("FAIL first_request: req=%b addr=%h ena=%b, want 1 %h 0", ic_req_valid,
                     ic_req_addr, pd_ena, RST_PC);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 9; i++) begin
            drive_idle();
            ic_resp_valid = (i % 3 == 1);
            ic_resp_inst  = 32'hA000_0000 + i;
            #1;
            checks++;
            if (iq_push !== 1'(i % 3 == 2) || ic_req_valid !== 1'(i % 3 == 0)) begin
                failures++;
                $display("FAIL seq_cadence cyc%0d: push=%b req=%b", i, iq_push, ic_req_valid);
            end
            if (i % 3 == 2) begin
                checks++;
                if (iq_pc !== 32'(4 * (i / 3)) || iq_inst !== 32'hA000_0000 + i - 1) begin
                    failures++;
                    $display("FAIL seq_push cyc%0d: pc=%h inst=%h, want %h %h", i, iq_pc,
                             iq_inst, 4 * (i / 3), 32'hA000_0000 + i - 1);
                end
            end
            tick();
        end
    endtask

    task automatic test_taken_branch();
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            ic_resp_valid = (i % 3 == 1);
            ic_resp_inst  = 32'hB000_0000 + i;
            if (i == 5) begin
                pd_taken_stat = 1'b1;
                pd_off        = 32'hFFFF_FFF8;
            end
            #1;
            if (i == 3) begin
                checks++;
                if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h10) begin
                    failures++;
                    $display("FAIL branch_fetch: req=%b addr=%h, want 1 10", ic_req_valid,
                             ic_req_addr);
                end
            end
            if (i == 5) begin
                checks++;
                if (iq_push !== 1'b1 || iq_pred_taken !== 1'b1 || iq_pc !== 32'h10) begin
                    failures++;
                    $display("FAIL branch_push: push=%b taken=%b pc=%h, want 1 1 10", iq_push,
                             iq_pred_taken, iq_pc);
                end
            end
            tick();
        end
        drive_idle();
        #1;
        checks++;
        if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h08) begin
            failures++;
            $display("FAIL branch_target: req=%b addr=%h, want 1 08", ic_req_valid, ic_req_addr);
        end
    endtask

    task automatic test_backpressure();
        int pushes;
        drive_idle();
        #1;
        tick();
        ic_resp_valid = 1'b1;
        ic_resp_inst  = 32'hCAFE_F00D;
        #1;
        tick();
        pushes = 0;
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            iq_full = 1'b1;
            #1;
            checks++;
            if (iq_push !== 1'b0 || pd_pc !== 32'h08 || pd_inst !== 32'hCAFE_F00D) begin
                failures++;
                $display("FAIL bp_hold cyc%0d: push=%b pd_pc=%h pd_inst=%h", i, iq_push, pd_pc,
                         pd_inst);
            end
            tick();
        end
        drive_idle();
        #1;
        checks++;
        if (iq_push !== 1'b1 || iq_pc !== 32'h08 || iq_inst !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL bp_release: push=%b pc=%h inst=%h, want 1 08 cafef00d", iq_push, iq_pc,
                     iq_inst);
        end
        tick();
        #1;
        checks++;
        if (iq_push !== 1'b0 || ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0C) begin
            failures++;
            $display("FAIL bp_no_dup: push=%b req=%b addr=%h, want 0 1 0c", iq_push,
                     ic_req_valid, ic_req_addr);
        end
    endtask

    task automatic test_flush_wait();
        drive_idle();
        flush    = 1'b1;
        flush_pc = 32'h20;
        #1;
        checks++;
        if (ic_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_fetch_req: req=%b, want 0", ic_req_valid);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h20) begin
            failures++;
            $display("FAIL flush_redirect: req=%b addr=%h, want 1 20", ic_req_valid, ic_req_addr);
        end
        tick();
        flush    = 1'b1;
        flush_pc = 32'h100;
        #1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            if (i == 2) begin
                ic_resp_valid = 1'b1;
                ic_resp_inst  = 32'hDEAD_BEEF;
            end
            #1;
            checks++;
            if (ic_req_valid !== 1'b0 || iq_push !== 1'b0) begin
                failures++;
                $display("FAIL drain_quiet cyc%0d: req=%b push=%b, want 0 0", i, ic_req_valid,
                         iq_push);
            end
            tick();
        end
        drive_idle();
        #1;
        checks++;
        if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h100 || pd_inst !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL drain_exit: req=%b addr=%h buf=%h, want 1 100 cafef00d", ic_req_valid,
                     ic_req_addr, pd_inst);
        end
        tick();
        ic_resp_valid = 1'b1;
        ic_resp_inst  = 32'h1234_5678;
        #1;
        tick();
        drive_idle();
        #1;
        checks++;
        if (iq_push !== 1'b1 || iq_inst !== 32'h1234_5678 || iq_pc !== 32'h100) begin
            failures++;
            $display("FAIL post_drain_push: push=%b inst=%h pc=%h, want 1 12345678 100", iq_push,
                     iq_inst, iq_pc);
        end
        tick();
    endtask

    task automatic test_flush_coincident();
        drive_idle();
        #1;
        tick();
        flush         = 1'b1;
        flush_pc      = 32'h200;
        ic_resp_valid = 1'b1;
        ic_resp_inst  = 32'hBAD0_0001;
        #1;
        tick();
        drive_idle();
        #1;
        checks++;
        if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h200 || pd_inst !== 32'h1234_5678) begin
            failures++;
            $display("FAIL flush_with_resp: req=%b addr=%h buf=%h, want 1 200 12345678",
                     ic_req_valid, ic_req_addr, pd_inst);
        end
        tick();
        flush    = 1'b1;
        flush_pc = 32'h200;
        #1;
        tick();
        flush_pc = 32'h300;
        #1;
        tick();
        drive_idle();
        #1;
        checks++;
        if (ic_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL double_flush_stay: req=%b, want 0", ic_req_valid);
        end
        tick();
        ic_resp_valid = 1'b1;
        #1;
        tick();
        drive_idle();
        #1;
        checks++;
        if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h300) begin
            failures++;
            $display("FAIL double_flush_addr: req=%b addr=%h, want 1 300", ic_req_valid,
                     ic_req_addr);
        end
        flush    = 1'b1;
        flush_pc = 32'h103;
        #1;
        tick();
        drive_idle();
        #1;
        checks++;
        if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h100) begin
            failures++;
            $display("FAIL flush_align: req=%b addr=%h, want 1 100", ic_req_valid, ic_req_addr);
        end
    endtask

    task automatic test_reset_mid();
        drive_idle();
        #1;
        tick();
        ic_resp_valid = 1'b1;
        ic_resp_inst  = 32'h5555_AAAA;
        #1;
        tick();
        drive_idle();
        rst = 1'b1;
        #1;
        checks++;
        if (iq_push !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_push: push=%b, want 0", iq_push);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (ic_req_valid !== 1'b1 || ic_req_addr !== RST_PC || pd_ena !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_restart: req=%b addr=%h ena=%b, want 1 %h 0", ic_req_valid,
                     ic_req_addr, pd_ena, RST_PC);
        end
    endtask

    task automatic test_random();
        bit e_req;
        bit e_push;
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            flush_pc      = $urandom;
            ic_resp_valid = m_inflight && !rst && $urandom_range(0, 1) == 1;
            ic_resp_inst  = $urandom;
            iq_full       = ($urandom_range(0, 2) == 0);
            pd_taken_stat = $urandom_range(0, 1) == 1;
            pd_off        = $urandom;
            #1;
            e_req  = !rst && !flush && m_need_req;
            e_push = !rst && !flush && m_ready && !iq_full;
            checks++;
            if (ic_req_valid !== e_req || (e_req && ic_req_addr !== m_pc)) begin
                failures++;
                if (failures < 30)
                    $display("FAIL rand_req cyc%0d: req=%b addr=%h, want %b %h", i, ic_req_valid,
                             ic_req_addr, e_req, m_pc);
            end
            checks++;
            if (iq_push !== e_push || (e_push && (iq_pc !== m_pc || iq_inst !== m_buf ||
                                                  iq_pred_taken !== pd_taken_stat))) begin
                failures++;
                if (failures < 30)
                    $display("FAIL rand_push cyc%0d: push=%b pc=%h inst=%h tk=%b, want %b %h %h %b",
                             i, iq_push, iq_pc, iq_inst, iq_pred_taken, e_push, m_pc, m_buf,
                             pd_taken_stat);
            end
            checks++;
            if (pd_pc !== m_pc || pd_inst !== m_buf || pd_ena !== m_ena) begin
                failures++;
                if (failures < 30)
                    $display("FAIL rand_pd cyc%0d: pc=%h inst=%h ena=%b, want %h %h %b", i, pd_pc,
                             pd_inst, pd_ena, m_pc, m_buf, m_ena);
            end
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_taken_branch();
        test_backpressure();
        test_flush_wait();
        test_flush_coincident();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
